// File: rtl/isa_pkg.sv
// Shared ISA definitions for the control stage and the accumulator ALU:
// instruction field positions, opcode encodings and the control FSM states.
package isa_pkg;

    // Instruction layout: {type_bit, op[3:0], reg[3:0]}
    localparam int INSTR_W  = 9;
    localparam int TYPE_BIT = 8;
    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 4;
    localparam int REG_MSB  = 3;
    localparam int REG_LSB  = 0;

    // Opcodes for type_bit = 0 instructions
    localparam logic [3:0] OP_TAKE   = 4'b0000;
    localparam logic [3:0] OP_PUT    = 4'b0001;
    localparam logic [3:0] OP_LOAD   = 4'b0010;
    localparam logic [3:0] OP_STORE  = 4'b0011;
    localparam logic [3:0] OP_XOR    = 4'b0100;
    localparam logic [3:0] OP_NAND   = 4'b0101;
    localparam logic [3:0] OP_SHL    = 4'b0110;
    localparam logic [3:0] OP_SHR    = 4'b0111;
    localparam logic [3:0] OP_LOOKUP = 4'b1000;
    localparam logic [3:0] OP_LSN    = 4'b1001;
    localparam logic [3:0] OP_EQL    = 4'b1010;
    localparam logic [3:0] OP_ADD    = 4'b1011;
    localparam logic [3:0] OP_SUB    = 4'b1100;
    localparam logic [3:0] OP_OF0    = 4'b1101;
    localparam logic [3:0] OP_HALT   = 4'b1110;
    localparam logic [3:0] OP_TBA    = 4'b1111;

    // Control sequencer states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALTED   = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/pc_ctrl.sv
// Fetch/decode/sequence control for the accumulator ALU. Owns the program
// counter, the architectural overflow flag and all write/memory enables.
// Optional feature: define PC_CTRL_MEM_TIMEOUT_EN to abort a load/store that
// waits MEM_TIMEOUT cycles without mem_ready (halts with err=1).
module pc_ctrl
    import isa_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                start,
    input  logic [INSTR_W-1:0]  instr,
    input  logic [7:0]          acc_val,
    input  logic                alu_ovf,
    input  logic                mem_ready,
    output logic [PC_W-1:0]     pc,
    output logic [3:0]          OP,
    output logic                type_bit,
    output logic [3:0]          reg_addr,
    output logic                ovf_flag,
    output logic                acc_we,
    output logic                reg_we,
    output logic                mem_req,
    output logic                mem_we,
    output logic                done,
    output logic                err
);

    ctrl_state_t     state;
    ctrl_state_t     state_next;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_off;
    logic            ovf_next;

    // The wait counter is 8 bits wide, so the limit has to fit in it.
    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_mem_timeout
        $error("pc_ctrl: MEM_TIMEOUT must be in 1..255");
    end

    assign type_bit = instr[TYPE_BIT];
    assign OP       = instr[OP_MSB:OP_LSB];
    assign reg_addr = instr[REG_MSB:REG_LSB];

    assign pc_inc = pc + PC_W'(1);
    assign br_off = PC_W'($signed(instr[OP_MSB:0]));
    assign done   = (state == HALTED);

`ifdef PC_CTRL_MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_q;
    logic       err_next;
    logic       timeout_hit;

    assign timeout_hit = (state == MEM_WAIT) && !mem_ready
                         && (wait_cnt == 8'(MEM_TIMEOUT - 1));
    assign err = err_q;

    // Wait counter sits at zero outside MEM_WAIT so it is clear on every entry.
    always_ff @(posedge CLK) begin
        if (!RESET_N || state != MEM_WAIT) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    assign err = 1'b0;
`endif

    // State, pc, overflow flag (and abort flag) registers.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state    <= IDLE;
            pc       <= '0;
            ovf_flag <= 1'b0;
`ifdef PC_CTRL_MEM_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            ovf_flag <= ovf_next;
`ifdef PC_CTRL_MEM_TIMEOUT_EN
            err_q    <= err_next;
`endif
        end
    end

    // Next-state, next-pc and enable decode from state and the current instruction.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ovf_next   = ovf_flag;
        acc_we     = 1'b0;
        reg_we     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
`ifdef PC_CTRL_MEM_TIMEOUT_EN
        err_next   = err_q;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end

            RUN: begin
                if (type_bit) begin
                    pc_next = (acc_val != 8'd0) ? pc + br_off : pc_inc;
                end else begin
                    case (OP)
                        OP_TAKE, OP_XOR, OP_NAND, OP_SHL, OP_SHR,
                        OP_LOOKUP, OP_LSN, OP_EQL, OP_SUB: begin
                            acc_we  = 1'b1;
                            pc_next = pc_inc;
                        end
                        OP_ADD: begin
                            acc_we   = 1'b1;
                            ovf_next = alu_ovf;
                            pc_next  = pc_inc;
                        end
                        OP_PUT: begin
                            reg_we  = 1'b1;
                            pc_next = pc_inc;
                        end
                        OP_LOAD: begin
                            mem_req    = 1'b1;
                            state_next = MEM_WAIT;
                        end
                        OP_STORE: begin
                            mem_req    = 1'b1;
                            mem_we     = 1'b1;
                            state_next = MEM_WAIT;
                        end
                        OP_OF0: begin
                            ovf_next = 1'b0;
                            pc_next  = pc_inc;
                        end
                        OP_HALT: begin
                            state_next = HALTED;
                        end
                        default: begin
                            pc_next = pc_inc;
                        end
                    endcase
                end
            end

            MEM_WAIT: begin
                mem_req = 1'b1;
                mem_we  = (OP == OP_STORE);
                if (mem_ready) begin
                    acc_we     = (OP == OP_LOAD);
                    pc_next    = pc_inc;
                    state_next = RUN;
                end
`ifdef PC_CTRL_MEM_TIMEOUT_EN
                else if (timeout_hit) begin
                    err_next   = 1'b1;
                    state_next = HALTED;
                end
`endif
            end

            HALTED: begin
                if (start) begin
                    pc_next    = '0;
                    ovf_next   = 1'b0;
`ifdef PC_CTRL_MEM_TIMEOUT_EN
                    err_next   = 1'b0;
`endif
                    state_next = RUN;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (!RESET_N) begin
            acc_we  = 1'b0;
            reg_we  = 1'b0;
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Fetch/decode/sequence control stage sitting directly upstream of the accumulator ALU.
- Drives the instruction-memory address (pc) and splits each 9-bit instruction into the ALU's OP, type_bit and register address.
- Owns the architectural overflow flag fed to the ALU's overflow_in, and generates the accumulator, register-file and data-memory enables.
- Sequences multi-cycle load/store, relative branches and halt.

Parameters:
- PC_W, 8: program counter width; instruction memory depth is 2^PC_W.
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before abort; used only with the optional feature.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  reset, synchronous and active-low.
- start  in  1  one-cycle pulse; leaves IDLE or HALTED.
- instr  in  9  instruction at pc, combinational ROM read; bit layout {type_bit, op[3:0], reg[3:0]}.
- acc_val  in  8  current accumulator value, used for branch decisions.
- alu_ovf  in  1  ALU overflow_out.
- mem_ready  in  1  data memory completion strobe.
- pc  out  PC_W  instruction address, registered.
- OP  out  4  instr[7:4].
- type_bit  out  1  instr[8].
- reg_addr  out  4  instr[3:0].
- ovf_flag  out  1  registered flag, drives ALU overflow_in.
- acc_we  out  1  write ALU OUT (or memory data on load) into the accumulator.
- reg_we  out  1  write ALU OUT into reg_addr.
- mem_req  out  1  data memory request.
- mem_we  out  1  qualifies mem_req as a store.
- done  out  1  high while HALTED.
- err  out  1  memory timeout abort; constant 0 without the optional feature.

Behaviour:
- Reset (RESET_N=0 at an edge), from any state including mid-MEM_WAIT:
  - state=IDLE, pc=0, ovf_flag=0, done=0, err=0.
  - All enables low in the same cycle while RESET_N=0.
- Decode:
  - OP, type_bit and reg_addr are combinational slices of instr in every state.
  - Enables are combinational from state and instr, and are asserted only in RUN or MEM_WAIT.
- FSM states: IDLE, RUN, MEM_WAIT, HALTED.
- IDLE:
  - Enables low.
  - start -> RUN with pc unchanged (0 after reset).
- RUN, type_bit=0, one instruction per cycle, pc <= pc+1 unless noted:
  - take 0000, xor 0100, nand 0101, shl 0110, shr 0111, lookup 1000, lsn 1001, eql 1010, add 1011, sub 1100: acc_we=1.
  - put 0001: reg_we=1.
  - load 0010 / store 0011: mem_req=1 (mem_we=1 for store). Go to MEM_WAIT; pc holds.
  - add 1011: ovf_flag <= alu_ovf.
  - of0 1101: ovf_flag <= 0; no writes.
  - halt 1110: go to HALTED; pc holds at the halt address; no writes.
  - tba 1111: no-op.
  - ovf_flag changes only on add and of0.
- RUN, type_bit=1 (branch):
  - Offset = instr[7:0], signed.
  - acc_val != 0: pc <= pc + sign-extended offset, modulo 2^PC_W.
  - acc_val == 0: pc <= pc+1.
  - No writes. Offset 0 taken is a legal self-loop.
- MEM_WAIT:
  - mem_req and mem_we held stable.
  - On mem_ready=1: acc_we=1 that cycle if load; pc <= pc+1; go to RUN.
  - mem_ready while in RUN is ignored.
- HALTED:
  - done=1, enables low.
  - start -> pc=0, ovf_flag=0, done=0, err=0, go to RUN.
- start in RUN or MEM_WAIT is ignored.
- pc increment wraps from 2^PC_W-1 to 0.

Optional Feature:
- Macro: PC_CTRL_MEM_TIMEOUT_EN.
- When defined:
  - An 8-bit wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
  - If it reaches MEM_TIMEOUT without mem_ready: go to HALTED with err=1, no acc_we, pc holds at the load/store address.
  - mem_ready in the same cycle the counter reaches MEM_TIMEOUT wins (normal completion).
- When undefined: no counter, err tied 0, MEM_WAIT waits indefinitely.

Decomposition:
- Shared package isa_pkg (also imported by the ALU):
  - 4-bit opcode localparams OP_TAKE through OP_TBA.
  - Instruction field bit positions.
  - FSM state enum ctrl_state_t {IDLE, RUN, MEM_WAIT, HALTED}.
- Single module; no sub-module is warranted. The timeout counter stays inline under the macro.

Test Plan:
- Reset, then start; program add(acc=0xF0, reg=0x20, ovf=0), halt:
  - cycle 1: acc_we=1, ovf_flag=1 after the edge;
  - cycle 2: done=1, pc=1.
- load with mem_ready asserted after 3 cycles:
  - mem_req=1 for 4 cycles;
  - acc_we=1 only in the ready cycle;
  - pc advances by exactly 1.
- Branch at pc=5, offset 0xFD:
  - acc_val=3 -> pc=2;
  - acc_val=0 -> pc=6;
  - pc=0x01 with offset 0xFE -> pc=0xFF (wrap).
- RESET_N low during MEM_WAIT: next cycle state=IDLE, pc=0, mem_req=0, ovf_flag=0.
- Sequence sub, of0, put:
  - ovf_flag unchanged by sub, cleared by of0;
  - put gives reg_we=1 with acc_we=0.
- With PC_CTRL_MEM_TIMEOUT_EN and mem_ready never asserted: after 16 wait cycles err=1, done=1, pc holds; start restarts at pc=0 with err=0.
